// File: rtl/ecp5pll_ctrl_pkg.sv
// Shared types and constants for the ECP5 PLL dynamic phase-shift sequencer.
package ecp5pll_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        GAP,
        PLLRST,
        WAIT_LOCK
    } state_t;

    localparam int unsigned NUM_OUT = 4;

    localparam logic [1:0] OUT_CLKOP  = 2'd0;
    localparam logic [1:0] OUT_CLKOS  = 2'd1;
    localparam logic [1:0] OUT_CLKOS2 = 2'd2;
    localparam logic [1:0] OUT_CLKOS3 = 2'd3;

    localparam logic DIR_DELAY   = 1'b0;
    localparam logic DIR_ADVANCE = 1'b1;

endpackage

// File: rtl/ecp5pll_lock_watchdog.sv
// LOCK synchronizer plus loss-of-lock timeout; fire_c is a one-cycle strobe.
module ecp5pll_lock_watchdog #(
    parameter int unsigned LOCK_TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic locked,
    output logic locked_s,
    output logic lock_lost,
    output logic fire_c
);

    localparam int unsigned TO_W = $clog2(LOCK_TIMEOUT + 1);

    logic            meta;
    logic [TO_W-1:0] cnt;

    // Fires on the LOCK_TIMEOUT-th consecutive cycle that sees locked_s low.
    assign fire_c = ~locked_s && (cnt == TO_W'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            meta      <= 1'b0;
            locked_s  <= 1'b0;
            cnt       <= '0;
            lock_lost <= 1'b0;
        end else begin
            meta     <= locked;
            locked_s <= meta;
            if (locked_s || fire_c) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + TO_W'(1);
            end
            if (fire_c) begin
                lock_lost <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ecp5pll_phase_ctrl.sv
// Request sequencer driving the ECP5 PLL dynamic phase port, with per-output
// phase accumulators and a lock watchdog that resets the PLL.
module ecp5pll_phase_ctrl
    import ecp5pll_ctrl_pkg::*;
#(
    parameter int unsigned STEP_SETUP   = 4,
    parameter int unsigned STEP_WIDTH   = 4,
    parameter int unsigned STEP_GAP     = 8,
    parameter int unsigned LOCK_TIMEOUT = 1000000,
    parameter int unsigned RST_WIDTH    = 16,
    parameter int unsigned PH_W         = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_sel,
    input  logic                    req_dir,
    input  logic [7:0]              req_steps,
    input  logic                    req_load,
    output logic                    done,
    output logic                    aborted,
    output logic                    busy,
    output logic [NUM_OUT*PH_W-1:0] phase_acc,
    input  logic                    locked,
    output logic                    locked_s,
    output logic                    lock_lost,
    output logic [1:0]              phasesel,
    output logic                    phasedir,
    output logic                    phasestep,
    output logic                    phaseloadreg,
    output logic                    pll_reset
);

    localparam int unsigned MAX_A   = (STEP_SETUP > STEP_WIDTH) ? STEP_SETUP : STEP_WIDTH;
    localparam int unsigned MAX_B   = (STEP_GAP > RST_WIDTH) ? STEP_GAP : RST_WIDTH;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [7:0]                       rem_q, rem_d;
    logic                             load_q, load_d;
    logic [1:0]                       sel_q, sel_d;
    logic                             dir_q, dir_d;
    logic                             ready_q, ready_d;
    logic                             done_q, done_d;
    logic                             aborted_q, aborted_d;
    logic                             busy_q, busy_d;
    logic                             step_q, step_d;
    logic                             loadreg_q, loadreg_d;
    logic                             pllrst_q, pllrst_d;
    logic [NUM_OUT-1:0][PH_W-1:0]     acc_q, acc_d;
    logic                             fire_c;
    logic                             accept_c;

    ecp5pll_lock_watchdog #(
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .locked    (locked),
        .locked_s  (locked_s),
        .lock_lost (lock_lost),
        .fire_c    (fire_c)
    );

    assign accept_c = (state_q == IDLE) && req_valid && ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            load_q    <= 1'b0;
            sel_q     <= '0;
            dir_q     <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
            step_q    <= 1'b0;
            loadreg_q <= 1'b0;
            pllrst_q  <= 1'b0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            load_q    <= load_d;
            sel_q     <= sel_d;
            dir_q     <= dir_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
            step_q    <= step_d;
            loadreg_q <= loadreg_d;
            pllrst_q  <= pllrst_d;
            acc_q     <= acc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        load_d    = load_q;
        sel_d     = sel_q;
        dir_d     = dir_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        busy_d    = busy_q;
        step_d    = step_q;
        loadreg_d = loadreg_q;
        pllrst_d  = pllrst_q;
        acc_d     = acc_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    sel_d   = req_sel;
                    dir_d   = req_dir;
                    load_d  = req_load;
                    rem_d   = req_load ? 8'd1 : req_steps;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // rem is 0 only for an empty non-load request: complete at once.
                if (rem_q == 8'd0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(STEP_SETUP)) begin
                    cnt_d     = '0;
                    step_d    = ~load_q;
                    loadreg_d = load_q;
                    state_d   = PULSE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt_q == CNT_W'(STEP_WIDTH - 1)) begin
                    step_d    = 1'b0;
                    loadreg_d = 1'b0;
                    rem_d     = rem_q - 8'd1;
                    cnt_d     = '0;
                    state_d   = GAP;
                    if (load_q) begin
                        acc_d[sel_q] = '0;
                    end else if (dir_q == DIR_ADVANCE) begin
                        acc_d[sel_q] = acc_q[sel_q] - PH_W'(1);
                    end else begin
                        acc_d[sel_q] = acc_q[sel_q] + PH_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(STEP_GAP - 1)) begin
                    cnt_d = '0;
                    if (rem_q != 8'd0) begin
                        step_d    = ~load_q;
                        loadreg_d = load_q;
                        state_d   = PULSE;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PLLRST: begin
                // PLL restarts at its static phase, so the accumulators restart too.
                if (cnt_q == CNT_W'(RST_WIDTH - 1)) begin
                    cnt_d    = '0;
                    pllrst_d = 1'b0;
                    acc_d    = '0;
                    state_d  = WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Watchdog overrides any completion on the same edge.
        if (fire_c) begin
            state_d   = PLLRST;
            cnt_d     = '0;
            rem_d     = '0;
            pllrst_d  = 1'b1;
            step_d    = 1'b0;
            loadreg_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = busy_q;
            aborted_d = busy_q;
        end

        ready_d = (state_d == IDLE) && locked_s && ~pllrst_d;
    end

    assign req_ready    = ready_q;
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign busy         = busy_q;
    assign phase_acc    = acc_q;
    assign phasesel     = sel_q;
    assign phasedir     = dir_q;
    assign phasestep    = step_q;
    assign phaseloadreg = loadreg_q;
    assign pll_reset    = pllrst_q;

endmodule
